// File: rtl/seq_control.sv
// Multi-cycle sequencer for the 8-bit accumulator datapath: Moore FSM decoding opcodes into load/bus strobes.
// Define SEQ_ILLEGAL_TRAP_EN to halt with illegal=1 on undefined opcodes; otherwise they behave as NOP.
module seq_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       CCR_Load,
  output logic [3:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [2:0] Bus2_Sel,
  output logic       addr_sel,
  output logic       mem_we,
  output logic       reg_we,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_OPND_IMM,
    S_OPND_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_EXEC_ALU,
    S_BRANCH,
    S_SKIP,
    S_HALT
  } state_t;

  typedef enum logic [7:0] {
    OP_NOP     = 8'h00,
    OP_BRA     = 8'h20,
    OP_BEQ     = 8'h23,
    OP_ADD_AB  = 8'h42,
    OP_LDA_IMM = 8'h86,
    OP_LDA_DIR = 8'h87,
    OP_STA_DIR = 8'h96,
    OP_HALT    = 8'hFF
  } opcode_t;

  localparam logic [2:0] BUS2_ALU = 3'b000;
  localparam logic [2:0] BUS2_MEM = 3'b010;
  localparam logic [1:0] BUS1_PC  = 2'b00;
  localparam logic [1:0] BUS1_A   = 2'b01;
  localparam logic [3:0] ALU_ADD  = 4'b0000;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_count;
  logic       w_z;
  logic       w_unused_flags;

  assign w_z            = CCR_Result[2];
  assign w_unused_flags = ^{CCR_Result[3], CCR_Result[1:0]};

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_trap;
`endif

  // Next-state logic; Z is looked at only while in DECODE.
  always_comb begin
    w_next = r_state;
`ifdef SEQ_ILLEGAL_TRAP_EN
    w_trap = 1'b0;
`endif
    unique case (r_state)
      S_FETCH:     w_next = S_DECODE;
      S_DECODE: begin
        case (IR)
          OP_LDA_IMM: w_next = S_OPND_IMM;
          OP_LDA_DIR: w_next = S_OPND_ADDR;
          OP_STA_DIR: w_next = S_OPND_ADDR;
          OP_ADD_AB:  w_next = S_EXEC_ALU;
          OP_BRA:     w_next = S_BRANCH;
          OP_BEQ:     w_next = w_z ? S_BRANCH : S_SKIP;
          OP_NOP:     w_next = S_FETCH;
          OP_HALT:    w_next = S_HALT;
          default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            w_next = S_HALT;
            w_trap = 1'b1;
`else
            w_next = S_FETCH;
`endif
          end
        endcase
      end
      S_OPND_IMM:  w_next = S_FETCH;
      S_OPND_ADDR: w_next = (IR == OP_STA_DIR) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    w_next = S_FETCH;
      S_MEM_WR:    w_next = S_FETCH;
      S_EXEC_ALU:  w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_SKIP:      w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_trap) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign instr_count = r_count;

  // Moore decode; reset gates every strobe so an abort takes effect without waiting for a clock.
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = ALU_ADD;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    addr_sel = 1'b0;
    mem_we   = 1'b0;
    reg_we   = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          Bus2_Sel = BUS2_MEM;
          IR_Load  = 1'b1;
          PC_Inc   = 1'b1;
        end
        S_DECODE: ;
        S_OPND_IMM: begin
          Bus2_Sel = BUS2_MEM;
          reg_we   = 1'b1;
          PC_Inc   = 1'b1;
        end
        S_OPND_ADDR: begin
          Bus2_Sel = BUS2_MEM;
          MAR_Load = 1'b1;
          PC_Inc   = 1'b1;
        end
        S_MEM_RD: begin
          addr_sel = 1'b1;
          Bus2_Sel = BUS2_MEM;
          reg_we   = 1'b1;
        end
        S_MEM_WR: begin
          addr_sel = 1'b1;
          Bus1_Sel = BUS1_A;
          mem_we   = 1'b1;
        end
        S_EXEC_ALU: begin
          Bus1_Sel = BUS1_A;
          ALU_Sel  = ALU_ADD;
          Bus2_Sel = BUS2_ALU;
          reg_we   = 1'b1;
          CCR_Load = 1'b1;
        end
        S_BRANCH: begin
          Bus2_Sel = BUS2_MEM;
          PC_Load  = 1'b1;
        end
        S_SKIP:  PC_Inc = 1'b1;
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control: per-opcode cycle tables from the instruction set drive a random
// instruction stream plus directed reset-abort, counter wrap and undefined-opcode cases.
module tb_seq_control;

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load;
  logic [3:0] ALU_Sel;
  logic [1:0] Bus1_Sel;
  logic [2:0] Bus2_Sel;
  logic       addr_sel, mem_we, reg_we, halted, illegal;
  logic [7:0] instr_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_cnt;
  logic [18:0] exp_q[$];
  logic [18:0] obs;

  seq_control dut (
    .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
    .addr_sel(addr_sel), .mem_we(mem_we), .reg_we(reg_we), .halted(halted),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {illegal, IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, ALU_Sel,
                Bus1_Sel, Bus2_Sel, addr_sel, mem_we, reg_we, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One control word: strobes, ALU=add always, bus selects, memory/reg controls, status.
  function automatic logic [18:0] uw(bit irl, bit mar, bit pcl, bit pci, bit ccr,
                                     logic [1:0] b1, logic [2:0] b2,
                                     bit as, bit we, bit rwe, bit h, bit il);
    return {il, irl, mar, pcl, pci, ccr, 4'b0000, b1, b2, as, we, rwe, h};
  endfunction

  function automatic bit is_defined(logic [7:0] op);
    return op inside {8'h86, 8'h87, 8'h96, 8'h42, 8'h20, 8'h23, 8'h00, 8'hFF};
  endfunction

  // Fills exp_q with the cycle-by-cycle words of one instruction; returns 1 if it ends in HALT.
  function automatic bit build(logic [7:0] op, bit z);
    logic [18:0] w_halt;
    bit          stops;
    stops  = 1'b0;
    w_halt = uw(0,0,0,0,0, 2'b00, 3'b000, 0,0,0, 1, 0);
    exp_q  = {};
    exp_q.push_back(uw(1,0,0,1,0, 2'b00, 3'b010, 0,0,0,0,0));
    exp_q.push_back(uw(0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    case (op)
      8'h86: exp_q.push_back(uw(0,0,0,1,0, 2'b00, 3'b010, 0,0,1,0,0));
      8'h87: begin
        exp_q.push_back(uw(0,1,0,1,0, 2'b00, 3'b010, 0,0,0,0,0));
        exp_q.push_back(uw(0,0,0,0,0, 2'b00, 3'b010, 1,0,1,0,0));
      end
      8'h96: begin
        exp_q.push_back(uw(0,1,0,1,0, 2'b00, 3'b010, 0,0,0,0,0));
        exp_q.push_back(uw(0,0,0,0,0, 2'b01, 3'b000, 1,1,0,0,0));
      end
      8'h42: exp_q.push_back(uw(0,0,0,0,1, 2'b01, 3'b000, 0,0,1,0,0));
      8'h20: exp_q.push_back(uw(0,0,1,0,0, 2'b00, 3'b010, 0,0,0,0,0));
      8'h23: begin
        if (z) exp_q.push_back(uw(0,0,1,0,0, 2'b00, 3'b010, 0,0,0,0,0));
        else   exp_q.push_back(uw(0,0,0,1,0, 2'b00, 3'b000, 0,0,0,0,0));
      end
      8'h00: ;
      8'hFF: begin
        stops = 1'b1;
        repeat (3) exp_q.push_back(w_halt);
      end
      default: begin
        if (TRAP) begin
          stops = 1'b1;
          repeat (3) exp_q.push_back(w_halt | 19'h40000);
        end
      end
    endcase
    return stops;
  endfunction

  task automatic tick(input bit was_decode);
    @(posedge clk);
    #1;
    if (was_decode) exp_cnt = exp_cnt + 8'd1;
  endtask

  // Called while the DUT is showing FETCH; returns with the next FETCH visible (or still in HALT).
  task automatic run_instr(input logic [7:0] op, input bit z, input int abort_at);
    bit stops;
    int n;
    stops = build(op, z);
    n = exp_q.size();
    IR = op;
    CCR_Result = {1'($urandom), z, 2'($urandom)};
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick(k == 2);
      check("uword", obs, exp_q[k]);
      check("count", instr_count, exp_cnt);
      if (k >= 2) CCR_Result = 4'($urandom);
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1;
        exp_cnt = 8'h00;
        check("abort_uword", obs, 19'h0);
        check("abort_count", instr_count, exp_cnt);
        @(posedge clk);
        #1;
        check("abort_hold", obs, 19'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        return;
      end
    end
    if (!stops) tick(n == 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_cnt = 8'h00;
    check("rst_uword", obs, 19'h0);
    check("rst_count", instr_count, exp_cnt);
    @(posedge clk);
    #1;
    check("rst_hold", obs, 19'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] pick_undefined();
    logic [7:0] v;
    v = 8'h77;
    for (int t = 0; t < 16; t++) begin
      v = 8'($urandom_range(0, 255));
      if (!is_defined(v)) return v;
    end
    return 8'h77;
  endfunction

  function automatic logic [7:0] pick_op();
    logic [7:0] ops [7];
    int unsigned r;
    ops = '{8'h86, 8'h87, 8'h96, 8'h42, 8'h20, 8'h23, 8'h00};
    r = $urandom_range(0, 7);
    if (r == 7) return TRAP ? 8'h00 : pick_undefined();
    return ops[r];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    IR = 8'h00;
    CCR_Result = 4'h0;
    exp_cnt = 8'h00;
    #1;
    check("por_uword", obs, 19'h0);
    check("por_count", instr_count, exp_cnt);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // LDA #imm then HALT
    run_instr(8'h86, 1'b0, -1);
    run_instr(8'hFF, 1'b0, -1);
    check("halt_count", instr_count, 8'd2);
    do_reset();

    // LDA dir, STA dir, BEQ taken / not taken
    run_instr(8'h87, 1'b0, -1);
    run_instr(8'h96, 1'b0, -1);
    run_instr(8'h23, 1'b1, -1);
    run_instr(8'h23, 1'b0, -1);

    for (int i = 0; i < 120; i++) begin
      run_instr(pick_op(), 1'($urandom), -1);
    end

    // Reset mid-STA in MEM_WR and mid-LDA in DECODE
    run_instr(8'h96, 1'b0, 3);
    run_instr(8'h87, 1'b0, 1);

    for (int i = 0; i < 256; i++) begin
      run_instr(8'h00, 1'b0, -1);
    end
    check("wrap_count", instr_count, 8'h00);

    run_instr(8'h77, 1'b0, -1);
    if (TRAP) do_reset();
    run_instr(pick_undefined(), 1'b1, -1);
    if (TRAP) do_reset();
    run_instr(8'h42, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
